// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store size
// codes, the request FSM states and the default test-status address.
package dmem_responder_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int unsigned TOHOST_ADDR_DEFAULT = 116;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/dmem_lane_ctl.sv
// Byte-lane steering for one access: byte enables and replicated store data
// on the write side, lane selection plus sign/zero extension on the read side,
// and detection of misaligned or illegal size codes.
module dmem_lane_ctl
   import dmem_responder_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_adr_lo,
   input  logic        i_store,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rword,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_load,
   output logic        o_misalign,
   output logic        o_illegal
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = i_rword[{i_adr_lo, 3'b000} +: 8];
   assign w_half = i_adr_lo[1] ? i_rword[31:16] : i_rword[15:0];

   // Decode size code into lane enables, store data and extended load value
   always_comb begin
      o_be       = 4'b0000;
      o_wdata    = i_wdata;
      o_load     = 32'h0;
      o_misalign = 1'b0;
      o_illegal  = 1'b0;
      case (i_funct3)
         F3_B, F3_BU: begin
            // Unsigned variants exist only for loads
            o_illegal = i_store & i_funct3[2];
            o_be      = 4'b0001 << i_adr_lo;
            o_wdata   = {4{i_wdata[7:0]}};
            o_load    = i_funct3[2] ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
         end
         F3_H, F3_HU: begin
            o_illegal  = i_store & i_funct3[2];
            o_misalign = i_adr_lo[0];
            o_be       = i_adr_lo[1] ? 4'b1100 : 4'b0011;
            o_wdata    = {2{i_wdata[15:0]}};
            o_load     = i_funct3[2] ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
         end
         F3_W: begin
            o_misalign = |i_adr_lo;
            o_be       = 4'b1111;
            o_load     = i_rword;
         end
         default: begin
            o_illegal = 1'b1;
         end
      endcase
      // A faulting access touches no lane and returns zero
      if (o_misalign || o_illegal) begin
         o_be   = 4'b0000;
         o_load = 32'h0;
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store request at a time, waits a
// fixed number of cycles, then pulses ready with the result. Stores commit in
// the response cycle; a word store to the test-status address is captured in
// tohost_data instead of the array.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 64,
   parameter int unsigned WAIT_STATES = 1,
   parameter int unsigned TOHOST_ADDR = TOHOST_ADDR_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        memwrite,
   input  logic [31:0] dataadr,
   input  logic [31:0] writedata,
   input  logic [2:0]  funct3,
   output logic [31:0] readdata,
   output logic        ready,
   output logic        err,
   output logic        tohost_valid,
   output logic [31:0] tohost_data
);

   localparam int unsigned AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [31:0] DEPTH_BYTES = 32'(4 * DEPTH_WORDS);
   localparam logic [31:0] TOHOST_A    = 32'(TOHOST_ADDR);

   state_t      r_state;
   state_t      w_state_next;
   logic [3:0]  r_cnt;
   logic [3:0]  w_cnt_next;
   logic        w_accept;

   logic        r_memwrite;
   logic [31:0] r_adr;
   logic [31:0] r_wdata;
   logic [2:0]  r_funct3;

   logic [31:0] r_tohost_data;
   logic        r_tohost_valid;

   logic [AW-1:0] w_idx;
   logic [31:0]   w_rword;
   logic [31:0]   w_rword_sel;
   logic [3:0]    w_be;
   logic [31:0]   w_wdata_sh;
   logic [31:0]   w_load;
   logic          w_misalign;
   logic          w_illegal;
   logic          w_is_tohost;
   logic          w_oor;
   logic          w_err;
   logic          w_resp;
   logic          w_mem_we;
   logic          w_tohost_we;

   // FSM state and wait counter; reset aborts any access in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // Next-state logic: IDLE -> WAIT on req, WAIT counts down, RESP lasts one cycle
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_accept     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (req) begin
               w_accept     = 1'b1;
               w_state_next = ST_WAIT;
               w_cnt_next   = 4'(WAIT_STATES);
            end
         end
         ST_WAIT: begin
            if (r_cnt == 4'd0) w_state_next = ST_RESP;
            else               w_cnt_next   = r_cnt - 4'd1;
         end
         ST_RESP: w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Capture request fields at acceptance so the access is immune to req dropping
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_memwrite <= 1'b0;
         r_adr      <= 32'h0;
         r_wdata    <= 32'h0;
         r_funct3   <= 3'b000;
      end else if (w_accept) begin
         r_memwrite <= memwrite;
         r_adr      <= dataadr;
         r_wdata    <= writedata;
         r_funct3   <= funct3;
      end
   end

   assign w_idx       = r_adr[AW+1:2];
   assign w_is_tohost = (r_adr == TOHOST_A);
   assign w_oor       = (r_adr >= DEPTH_BYTES) && !w_is_tohost;
   assign w_rword_sel = w_is_tohost ? r_tohost_data : w_rword;

   dmem_lane_ctl u_lane_ctl (
      .i_funct3   (r_funct3),
      .i_adr_lo   (r_adr[1:0]),
      .i_store    (r_memwrite),
      .i_wdata    (r_wdata),
      .i_rword    (w_rword_sel),
      .o_be       (w_be),
      .o_wdata    (w_wdata_sh),
      .o_load     (w_load),
      .o_misalign (w_misalign),
      .o_illegal  (w_illegal)
   );

   assign w_err       = w_misalign | w_illegal | w_oor;
   assign w_resp      = (r_state == ST_RESP);
   assign w_mem_we    = w_resp & r_memwrite & ~w_err & ~w_is_tohost;
   assign w_tohost_we = w_resp & r_memwrite & ~w_err & w_is_tohost & (r_funct3 == F3_W);

   // One byte-wide array per lane; the read is registered every cycle so the
   // word is ready by the time the FSM reaches RESP
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] r_mem [DEPTH_WORDS];
         logic [7:0] r_rd;
         // Lane write on commit, unconditional registered read
         always_ff @(posedge clk) begin
            if (w_mem_we && w_be[gi]) r_mem[w_idx] <= w_wdata_sh[8*gi +: 8];
            r_rd <= r_mem[w_idx];
         end
         assign w_rword[8*gi +: 8] = r_rd;
      end
   endgenerate

   // Test-status register: sticky valid plus last word stored
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tohost_valid <= 1'b0;
         r_tohost_data  <= 32'h0;
      end else if (w_tohost_we) begin
         r_tohost_valid <= 1'b1;
         r_tohost_data  <= r_wdata;
      end
   end

   assign ready        = w_resp;
   assign err          = w_resp & w_err;
   assign readdata     = (w_resp && !w_err) ? w_load : 32'h0;
   assign tohost_valid = r_tohost_valid;
   assign tohost_data  = r_tohost_data;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: the driver pushes the expected
// response of each request, a monitor pops and compares on every ready pulse.
module tb_dmem_responder;

   localparam int WS = 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic        memwrite;
   logic [31:0] dataadr;
   logic [31:0] writedata;
   logic [2:0]  funct3;
   logic [31:0] readdata;
   logic        ready;
   logic        err;
   logic        tohost_valid;
   logic [31:0] tohost_data;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      string       nm;
      logic        err;
      logic        is_load;
      logic [31:0] rd;
      int          rdy_cyc;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;

   dmem_responder #(
      .DEPTH_WORDS (64),
      .WAIT_STATES (WS),
      .TOHOST_ADDR (116)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req          (req),
      .memwrite     (memwrite),
      .dataadr      (dataadr),
      .writedata    (writedata),
      .funct3       (funct3),
      .readdata     (readdata),
      .ready        (ready),
      .err          (err),
      .tohost_valid (tohost_valid),
      .tohost_data  (tohost_data)
   );

   always #5 clk = ~clk;

   // Cycle index used for latency checks
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%08h want=%08h", nm, act, exp);
      end
   endtask

   // Issue one request, record its expected response, hold req until ready
   task automatic issue(input string nm, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] f3,
                        input logic exp_err, input logic [31:0] exp_rd);
      exp_t e;
      bit   seen;
      @(negedge clk);
      e.nm      = nm;
      e.err     = exp_err;
      e.is_load = !we;
      e.rd      = exp_rd;
      e.rdy_cyc = cyc + WS + 2;
      sb_q.push_back(e);
      memwrite  = we;
      dataadr   = a;
      writedata = wd;
      funct3    = f3;
      req       = 1'b1;
      seen      = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (ready) begin
            seen = 1'b1;
            break;
         end
      end
      req = 1'b0;
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: got=no_ready want=ready", nm);
      end
   endtask

   // Monitor: compare every ready pulse against the head of the scoreboard
   always @(negedge clk) begin
      if (reset && ready) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ready: got=1 want=0");
         end else begin
            mon_e = sb_q.pop_front();
            $display("txn %s err=%0b rdata=%08h cyc=%0d", mon_e.nm, err, readdata, cyc);
            chk({mon_e.nm, "_err"}, {31'h0, err}, {31'h0, mon_e.err});
            if (mon_e.is_load) chk({mon_e.nm, "_rdata"}, readdata, mon_e.rd);
            chk({mon_e.nm, "_latency"}, cyc, mon_e.rdy_cyc);
         end
      end
   end

   initial begin
      reset     = 1'b0;
      req       = 1'b0;
      memwrite  = 1'b0;
      dataadr   = 32'h0;
      writedata = 32'h0;
      funct3    = 3'b010;
      repeat (2) @(negedge clk);
      chk("rst_ready",    {31'h0, ready},        32'h0);
      chk("rst_err",      {31'h0, err},          32'h0);
      chk("rst_readdata", readdata,              32'h0);
      chk("rst_tvalid",   {31'h0, tohost_valid}, 32'h0);
      chk("rst_tdata",    tohost_data,           32'h0);
      reset = 1'b1;

      // Basic word access and read-after-write
      issue("sw8",    1'b1, 32'd8, 32'h12345678, 3'b010, 1'b0, 32'h0);
      issue("lw8",    1'b0, 32'd8, 32'h0,        3'b010, 1'b0, 32'h12345678);

      // Byte store into a cleared word, then extended loads
      issue("sw8_0",  1'b1, 32'd8, 32'h0,        3'b010, 1'b0, 32'h0);
      issue("sb9",    1'b1, 32'd9, 32'h000000F0, 3'b000, 1'b0, 32'h0);
      issue("lb9",    1'b0, 32'd9, 32'h0,        3'b000, 1'b0, 32'hFFFFFFF0);
      issue("lbu9",   1'b0, 32'd9, 32'h0,        3'b100, 1'b0, 32'h000000F0);
      issue("lw8b",   1'b0, 32'd8, 32'h0,        3'b010, 1'b0, 32'h0000F000);

      // Misaligned accesses against a known word 0
      issue("sw0",    1'b1, 32'd0, 32'hCAFEBABE, 3'b010, 1'b0, 32'h0);
      issue("sh3",    1'b1, 32'd3, 32'h00001111, 3'b001, 1'b1, 32'h0);
      issue("lw0",    1'b0, 32'd0, 32'h0,        3'b010, 1'b0, 32'hCAFEBABE);
      issue("lw2",    1'b0, 32'd2, 32'h0,        3'b010, 1'b1, 32'h0);
      issue("lh2",    1'b0, 32'd2, 32'h0,        3'b001, 1'b0, 32'hFFFFCAFE);
      issue("lhu2",   1'b0, 32'd2, 32'h0,        3'b101, 1'b0, 32'h0000CAFE);

      // Test-status register
      issue("sw116",  1'b1, 32'd116, 32'd6,      3'b010, 1'b0, 32'h0);
      @(negedge clk);
      chk("tohost_valid", {31'h0, tohost_valid}, 32'h1);
      chk("tohost_data",  tohost_data,           32'd6);
      issue("lw116",  1'b0, 32'd116, 32'h0,      3'b010, 1'b0, 32'd6);

      // Out of range: 256 aliases word 0 in the index bits, which must stay intact
      issue("sw256",  1'b1, 32'd256, 32'h55,     3'b010, 1'b1, 32'h0);
      issue("lw256",  1'b0, 32'd256, 32'h0,      3'b010, 1'b1, 32'h0);
      issue("lw0b",   1'b0, 32'd0, 32'h0,        3'b010, 1'b0, 32'hCAFEBABE);

      // Illegal size codes
      issue("ld011",  1'b0, 32'd0, 32'h0,        3'b011, 1'b1, 32'h0);
      issue("sbu0",   1'b1, 32'd0, 32'h77,       3'b100, 1'b1, 32'h0);
      issue("lw0c",   1'b0, 32'd0, 32'h0,        3'b010, 1'b0, 32'hCAFEBABE);

      // Reset in the middle of a store aborts it
      issue("sw4",    1'b1, 32'd4, 32'hAAAA5555, 3'b010, 1'b0, 32'h0);
      @(negedge clk);
      memwrite  = 1'b1;
      dataadr   = 32'd4;
      writedata = 32'hDEADBEEF;
      funct3    = 3'b010;
      req       = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      req   = 1'b0;
      #1;
      chk("midrst_tvalid", {31'h0, tohost_valid}, 32'h0);
      chk("midrst_tdata",  tohost_data,           32'h0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("midrst_ready", {31'h0, ready}, 32'h0);
      end
      reset = 1'b1;
      repeat (3) @(negedge clk);
      issue("lw4",    1'b0, 32'd4, 32'h0,        3'b010, 1'b0, 32'hAAAA5555);

      repeat (3) @(negedge clk);
      chk("sb_drained", 32'(sb_q.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
